// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// owner identifiers and request field widths.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;
  localparam int STARVE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t OWN_I = 1'b0;
  localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order record of which master owns each accepted transaction still
// waiting for its data phase. Entry 0 is always the head.
import mem_arbiter_pkg::*;

module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  owner_t push_id,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_t head
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             push_eff, pop_eff;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head     = mem_q[0];
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);

  // Shift on pop; a simultaneous push lands one slot lower so order holds.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = cnt_q;
    if (pop_eff) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      wr_idx = cnt_q - 1'b1;
    end
    if (push_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) mem_d[i] = push_id;
      end
    end
    cnt_d = cnt_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction and a data master onto one split-transaction
// memory port; data wins unless instruction fetch has starved too long.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [SIZE_W-1:0] m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [STRB_W-1:0] m_wstrb,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                inst_wins;
  logic                push;
  owner_t              push_id;
  logic                fifo_full, fifo_empty;
  owner_t              fifo_head;

  assign inst_wins = inst_req && (!data_req || int'(starve_q) >= STARVE_LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_full && (inst_req || data_req))
          state_d = inst_wins ? ST_GRANT_I : ST_GRANT_D;
      end
      ST_GRANT_I: if (!inst_req || m_addr_ok) state_d = ST_IDLE;
      ST_GRANT_D: if (!data_req || m_addr_ok) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Starvation is counted per arbitration decision that passes over inst.
    if (!inst_req || (state_q == ST_IDLE && state_d == ST_GRANT_I))
      starve_d = '0;
    else if (state_q == ST_IDLE && state_d == ST_GRANT_D && starve_q != '1)
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    m_req        = 1'b0;
    m_wr         = inst_wr;
    m_size       = inst_size;
    m_addr       = inst_addr;
    m_wstrb      = inst_wstrb;
    m_wdata      = inst_wdata;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    push_id      = OWN_I;
    case (state_q)
      ST_GRANT_I: begin
        m_req        = inst_req;
        inst_addr_ok = m_addr_ok;
      end
      ST_GRANT_D: begin
        m_req        = data_req;
        m_wr         = data_wr;
        m_size       = data_size;
        m_addr       = data_addr;
        m_wstrb      = data_wstrb;
        m_wdata      = data_wdata;
        data_addr_ok = m_addr_ok;
        push_id      = OWN_D;
      end
      default: ;
    endcase
    push = m_req & m_addr_ok;
  end

  assign inst_data_ok = m_data_ok & ~fifo_empty & (fifo_head == OWN_I);
  assign data_data_ok = m_data_ok & ~fifo_empty & (fifo_head == OWN_D);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  arb_owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .push_id (push_id),
    .pop     (m_data_ok),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule
